// File: rtl/rx_deframer.sv
// RX frame consumer: hunts for frame headers, strips header/timestamp/FCS, forwards payload
// with ready/valid and checks CRC-16. Sequence tracking is built only with RX_DEFRAMER_SEQ_CHECK_EN.
module rx_deframer #(
  parameter int NB_SAMPLES = 256
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_empty,
  input  logic [31:0] i_data,
  output logic        o_read,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic        o_sof,
  output logic        o_eof,
  input  logic        i_ready,
  output logic [63:0] o_timestamp,
  output logic        o_frame_done,
  output logic        o_crc_ok,
  output logic        o_seq_err,
  input  logic        i_clr_cnt,
  output logic [15:0] o_crc_err_cnt,
  output logic [15:0] o_seq_err_cnt,
  output logic [15:0] o_sync_loss_cnt
);

  typedef enum logic [2:0] {HUNT, TS_MSB, TS_LSB, PAYLOAD, FCS} state_e;

  localparam int CW = 10;
  localparam logic [CW-1:0] CNT_LAST = CW'(NB_SAMPLES - 1);

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [31:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc, input logic clr);
    if (clr) return 16'h0000;
    if (inc && (v != 16'hFFFF)) return v + 16'd1;
    return v;
  endfunction

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [15:0]    crc_q, crc_d;
  logic [31:0]    ts_hi_q, ts_hi_d;
  logic [63:0]    ts_q, ts_d;
  logic           valid_q, valid_d;
  logic [31:0]    data_q, data_d;
  logic           sof_q, sof_d;
  logic           eof_q, eof_d;
  logic           done_q, done_d;
  logic           crc_ok_q, crc_ok_d;
  logic [15:0]    crc_cnt_q, sync_cnt_q;
  logic           pop, is_hdr, fcs_bad, crc_fail;

  assign is_hdr = (i_data[31:16] == 16'hCAFE) && !i_data[15];
  // The payload register may only be overwritten once its current word has been taken.
  assign pop    = !i_empty && ((state_q != PAYLOAD) || !valid_q || i_ready);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    crc_d    = crc_q;
    ts_hi_d  = ts_hi_q;
    ts_d     = ts_q;
    valid_d  = valid_q && !i_ready;
    data_d   = data_q;
    sof_d    = sof_q;
    eof_d    = eof_q;
    done_d   = 1'b0;
    crc_ok_d = crc_ok_q;
    fcs_bad  = 1'b0;
    crc_fail = 1'b0;
    if (pop) begin
      case (state_q)
        HUNT:    if (is_hdr) state_d = TS_MSB;
        TS_MSB: begin
          ts_hi_d = i_data;
          state_d = TS_LSB;
        end
        TS_LSB: begin
          ts_d    = {ts_hi_q, i_data};
          crc_d   = 16'hFFFF;
          cnt_d   = CNT_LAST;
          state_d = PAYLOAD;
        end
        PAYLOAD: begin
          valid_d = 1'b1;
          data_d  = i_data;
          sof_d   = (cnt_q == CNT_LAST);
          eof_d   = (cnt_q == '0);
          crc_d   = crc16_step(crc_q, i_data);
          if (cnt_q == '0) state_d = FCS;
          else             cnt_d   = cnt_q - 1'b1;
        end
        FCS: begin
          done_d  = 1'b1;
          state_d = HUNT;
          if (i_data[31:16] == 16'hC0DE) begin
            crc_ok_d = (crc_q == i_data[15:0]);
            crc_fail = (crc_q != i_data[15:0]);
          end else begin
            crc_ok_d = 1'b0;
            fcs_bad  = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= HUNT;
      cnt_q      <= '0;
      crc_q      <= 16'hFFFF;
      ts_hi_q    <= '0;
      ts_q       <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      done_q     <= 1'b0;
      crc_ok_q   <= 1'b0;
      crc_cnt_q  <= '0;
      sync_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      ts_hi_q    <= ts_hi_d;
      ts_q       <= ts_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      done_q     <= done_d;
      crc_ok_q   <= crc_ok_d;
      crc_cnt_q  <= sat_inc(crc_cnt_q, crc_fail, i_clr_cnt);
      sync_cnt_q <= sat_inc(sync_cnt_q, fcs_bad, i_clr_cnt);
    end
  end

`ifdef RX_DEFRAMER_SEQ_CHECK_EN
  logic [14:0] seq_ref_q;
  logic        ref_valid_q, seq_pend_q, seq_err_q;
  logic [15:0] seq_cnt_q;
  logic        hdr_hit, fcs_done;

  assign hdr_hit  = pop && (state_q == HUNT) && is_hdr;
  assign fcs_done = pop && (state_q == FCS);

  // The discontinuity is judged at the header but reported with that frame's status pulse.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      seq_ref_q   <= '0;
      ref_valid_q <= 1'b0;
      seq_pend_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      seq_cnt_q   <= '0;
    end else begin
      if (hdr_hit) begin
        seq_pend_q  <= ref_valid_q && (i_data[14:0] != seq_ref_q + 15'd1);
        seq_ref_q   <= i_data[14:0];
        ref_valid_q <= 1'b1;
      end
      if (fcs_done) begin
        seq_err_q <= seq_pend_q;
        if (fcs_bad) ref_valid_q <= 1'b0;
      end
      seq_cnt_q <= sat_inc(seq_cnt_q, fcs_done && seq_pend_q, i_clr_cnt);
    end
  end

  assign o_seq_err     = seq_err_q;
  assign o_seq_err_cnt = seq_cnt_q;
`else
  assign o_seq_err     = 1'b0;
  assign o_seq_err_cnt = 16'h0000;
`endif

  assign o_read          = pop;
  assign o_valid         = valid_q;
  assign o_data          = data_q;
  assign o_sof           = sof_q;
  assign o_eof           = eof_q;
  assign o_timestamp     = ts_q;
  assign o_frame_done    = done_q;
  assign o_crc_ok        = crc_ok_q;
  assign o_crc_err_cnt   = crc_cnt_q;
  assign o_sync_loss_cnt = sync_cnt_q;

endmodule

// File: tb/tb_rx_deframer.sv
// Scoreboard bench for rx_deframer: a FIFO model feeds generated frames, a reference model
// queues expected payload words and frame status, and a monitor process compares them.
module tb_rx_deframer;
  localparam int NB = 256;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_empty;
  logic [31:0] i_data;
  logic        o_read;
  logic        o_valid;
  logic [31:0] o_data;
  logic        o_sof;
  logic        o_eof;
  logic        i_ready;
  logic [63:0] o_timestamp;
  logic        o_frame_done;
  logic        o_crc_ok;
  logic        o_seq_err;
  logic        i_clr_cnt;
  logic [15:0] o_crc_err_cnt;
  logic [15:0] o_seq_err_cnt;
  logic [15:0] o_sync_loss_cnt;

  rx_deframer #(.NB_SAMPLES(NB)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_empty(i_empty), .i_data(i_data),
    .o_read(o_read), .o_valid(o_valid), .o_data(o_data), .o_sof(o_sof), .o_eof(o_eof),
    .i_ready(i_ready), .o_timestamp(o_timestamp), .o_frame_done(o_frame_done),
    .o_crc_ok(o_crc_ok), .o_seq_err(o_seq_err), .i_clr_cnt(i_clr_cnt),
    .o_crc_err_cnt(o_crc_err_cnt), .o_seq_err_cnt(o_seq_err_cnt),
    .o_sync_loss_cnt(o_sync_loss_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] data;
    logic        sof;
    logic        eof;
  } pay_t;

  typedef struct {
    logic        crc_ok;
    logic        seq_err;
    logic [15:0] crc_cnt;
    logic [15:0] seq_cnt;
    logic [15:0] sync_cnt;
    logic [63:0] ts;
  } stat_t;

  pay_t        exp_pay[$];
  stat_t       exp_stat[$];
  logic [31:0] fifo[$];

  int n_cmp = 0;
  int n_fail = 0;
  int n_acc = 0;
  int ready_mode = 0;
  bit rand_empty = 0;

  bit          ref_valid = 0;
  logic [14:0] seq_ref = '0;
  logic [15:0] m_crc_cnt = '0, m_seq_cnt = '0, m_sync_cnt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [31:0] w);
    logic [15:0] c;
    c = crc;
    for (int b = 31; b >= 0; b--) begin
      if (c[15] ^ w[b]) c = (c << 1) ^ 16'h1021;
      else              c = c << 1;
    end
    return c;
  endfunction

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Builds one frame into the FIFO model and queues what the deframer should produce.
  task automatic push_frame(input logic [14:0] seq, input logic [63:0] ts, input bit rnd,
                            input int flip_idx, input bit bad_fcs, input int keep_words);
    logic [31:0] w;
    logic [15:0] crc_orig, crc_tx;
    stat_t       s;
    bit          serr;
    fifo.push_back({16'hCAFE, 1'b0, seq});
    fifo.push_back(ts[63:32]);
    fifo.push_back(ts[31:0]);
    crc_orig = 16'hFFFF;
    crc_tx   = 16'hFFFF;
    for (int i = 0; i < NB; i++) begin
      w = rnd ? $urandom : 32'(i);
      crc_orig = crc16_word(crc_orig, w);
      if (i == flip_idx) w = w ^ 32'h1;
      crc_tx = crc16_word(crc_tx, w);
      fifo.push_back(w);
      if (i < keep_words) exp_pay.push_back('{data: w, sof: (i == 0), eof: (i == NB - 1)});
    end
    fifo.push_back(bad_fcs ? 32'h1234_0000 : {16'hC0DE, crc_orig});
    if (keep_words < NB) return;
`ifdef RX_DEFRAMER_SEQ_CHECK_EN
    serr      = ref_valid && (seq != 15'(seq_ref + 15'd1));
    seq_ref   = seq;
    ref_valid = 1'b1;
`else
    serr = 1'b0;
`endif
    s.crc_ok = !bad_fcs && (crc_tx == crc_orig);
    if (bad_fcs) begin
      m_sync_cnt = sat16(m_sync_cnt);
      ref_valid  = 1'b0;
    end else if (!s.crc_ok) begin
      m_crc_cnt = sat16(m_crc_cnt);
    end
    if (serr) m_seq_cnt = sat16(m_seq_cnt);
    s.seq_err  = serr;
    s.crc_cnt  = m_crc_cnt;
    s.seq_cnt  = m_seq_cnt;
    s.sync_cnt = m_sync_cnt;
    s.ts       = ts;
    exp_stat.push_back(s);
  endtask

  // Called at a falling edge: drive inputs, mirror the pop, return at the next falling edge.
  task automatic step();
    i_clr_cnt = 1'b0;
    case (ready_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = ~i_ready;
      default: i_ready = 1'($urandom_range(0, 1));
    endcase
    i_empty = (fifo.size() == 0) || (rand_empty && ($urandom_range(0, 3) == 0));
    i_data  = (fifo.size() != 0) ? fifo[0] : $urandom;
    #4;
    if (o_read) begin
      check("no_pop_when_empty", i_empty, 1'b0);
      if (!i_empty) void'(fifo.pop_front());
    end
    @(negedge i_clk);
  endtask

  task automatic drain();
    bit idle;
    idle = 0;
    for (int c = 0; c < 20000; c++) begin
      if (fifo.size() == 0 && exp_pay.size() == 0 && exp_stat.size() == 0) begin
        idle = 1;
        break;
      end
      step();
    end
    check("drain_idle", idle, 1'b1);
    repeat (4) step();
  endtask

  // Monitor: compares every accepted payload word and every status pulse with the queues.
  initial begin
    pay_t        e;
    stat_t       s;
    bit          stall_prev;
    logic [33:0] prev;
    stall_prev = 0;
    prev = '0;
    forever begin
      @(negedge i_clk);
      #4;
      if (!i_reset_n) begin
        stall_prev = 0;
      end else begin
        if (stall_prev) check("stall_hold", {o_valid, o_data, o_sof, o_eof}, {1'b1, prev});
        if (o_valid && i_ready) begin
          check("payload_expected", exp_pay.size() != 0, 1'b1);
          if (exp_pay.size() != 0) begin
            e = exp_pay.pop_front();
            check("payload_data", o_data, e.data);
            check("payload_sof_eof", {o_sof, o_eof}, {e.sof, e.eof});
            n_acc++;
          end
        end
        if (o_frame_done) begin
          check("status_expected", exp_stat.size() != 0, 1'b1);
          if (exp_stat.size() != 0) begin
            s = exp_stat.pop_front();
            check("crc_ok", o_crc_ok, s.crc_ok);
            check("seq_err", o_seq_err, s.seq_err);
            check("crc_err_cnt", o_crc_err_cnt, s.crc_cnt);
            check("seq_err_cnt", o_seq_err_cnt, s.seq_cnt);
            check("sync_loss_cnt", o_sync_loss_cnt, s.sync_cnt);
            check("timestamp", o_timestamp, s.ts);
          end
        end
        stall_prev = o_valid && !i_ready;
        prev = {o_data, o_sof, o_eof};
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, o_valid, 1'b0);
    check({tag, "_sof_eof"}, {o_sof, o_eof}, 2'b00);
    check({tag, "_data"}, o_data, 32'h0);
    check({tag, "_timestamp"}, o_timestamp, 64'h0);
    check({tag, "_status"}, {o_frame_done, o_crc_ok, o_seq_err}, 3'b000);
    check({tag, "_counters"}, {o_crc_err_cnt, o_seq_err_cnt, o_sync_loss_cnt}, 48'h0);
  endtask

  initial begin
    int          base;
    logic [14:0] s0;
    i_reset_n = 1'b0;
    i_empty   = 1'b1;
    i_data    = '0;
    i_ready   = 1'b1;
    i_clr_cnt = 1'b0;
    #12;
    check_reset_values("reset");
    check("reset_no_read", o_read, 1'b0);
    @(negedge i_clk);
    i_reset_n = 1'b1;

    // Back-to-back clean frames, counting payload, full throughput.
    ready_mode = 0; rand_empty = 0;
    push_frame(15'd5, 64'h0123_4567_89AB_CDEF, 0, -1, 0, NB);
    push_frame(15'd6, 64'h0123_4567_89AB_CDF0, 0, -1, 0, NB);
    drain();

    // Single-bit corruption of payload word 17.
    push_frame(15'd7, 64'h0000_0000_0000_0100, 0, 17, 0, NB);
    drain();

    // Sequence jumps with random backpressure.
    ready_mode = 2;
    push_frame(15'd5, 64'h10, 1, -1, 0, NB);
    push_frame(15'd9, 64'h11, 1, -1, 0, NB);
    push_frame(15'd10, 64'h12, 1, -1, 0, NB);
    drain();

    // Garbage before a header, then a frame with a broken FCS word, then a clean frame.
    repeat (3) fifo.push_back(32'hDEAD_BEEF);
    push_frame(15'd11, 64'h20, 1, -1, 1, NB);
    push_frame(15'd12, 64'h21, 1, -1, 0, NB);
    drain();

    // Toggling ready, random FIFO gaps, mostly consecutive sequence numbers.
    ready_mode = 1; rand_empty = 1;
    for (int f = 0; f < 3; f++) begin
      s0 = ($urandom_range(0, 2) == 0) ? 15'($urandom) : 15'(seq_ref + 15'd1);
      push_frame(s0, 64'h0000_0001_0000_00FA, 1, -1, 0, NB);
    end
    drain();

    // Counter clear.
    i_clr_cnt = 1'b1;
    @(negedge i_clk);
    i_clr_cnt = 1'b0;
    m_crc_cnt = '0; m_seq_cnt = '0; m_sync_cnt = '0;
    #1;
    check("clr_counters", {o_crc_err_cnt, o_seq_err_cnt, o_sync_loss_cnt}, 48'h0);
    @(negedge i_clk);

    // Reset in the middle of a frame's payload.
    ready_mode = 0; rand_empty = 0;
    base = n_acc;
    push_frame(15'($urandom), 64'h30, 1, -1, 0, 100);
    for (int c = 0; c < 2000; c++) begin
      if (n_acc - base >= 100) break;
      step();
    end
    check("words_before_reset", n_acc - base, 100);
    i_reset_n = 1'b0;
    i_empty   = 1'b1;
    fifo.delete();
    ref_valid = 1'b0;
    m_crc_cnt = '0; m_seq_cnt = '0; m_sync_cnt = '0;
    #1;
    check_reset_values("midreset");
    check("midreset_no_leftover", exp_pay.size() + exp_stat.size(), 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    s0 = 15'($urandom);
    push_frame(s0, 64'h40, 1, -1, 0, NB);
    push_frame(15'(s0 + 15'd3), 64'h41, 1, -1, 0, NB);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_deframer.md
# rx_deframer

Consumer stage for the RX frame stream: reads 32-bit framed words from the RX FIFO, locks onto frame boundaries, strips header/timestamp/FCS, and forwards payload samples downstream with ready/valid backpressure. Checks the per-frame CRC-16 and the 15-bit sequence number, reports a per-frame status pulse and keeps saturating error counters. Sits between the RX framer's output FIFO and the sample consumer (SPI/SMI streaming path).

## Interface
- NB_SAMPLES, 256: payload words per frame (1..1024).
- i_clk  in  1  clock; all logic on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_empty  in  1  input FIFO empty; i_data valid whenever low (first-word-fall-through).
- i_data  in  32  input FIFO head word.
- o_read  out  1  FIFO pop, combinational.
- o_valid  out  1  payload word valid.
- o_data  out  32  payload word.
- o_sof / o_eof  out  1  first / last payload word of frame, qualified by o_valid.
- i_ready  in  1  downstream accepts o_data when o_valid & i_ready.
- o_timestamp  out  64  timestamp of current frame.
- o_frame_done  out  1  one-cycle pulse, frame status valid.
- o_crc_ok  out  1  CRC result of last frame.
- o_seq_err  out  1  sequence discontinuity on last frame.
- i_clr_cnt  in  1  synchronous clear of all counters.
- o_crc_err_cnt, o_seq_err_cnt, o_sync_loss_cnt  out  16 each  saturating counters.

## Operation
- Frame format: header {16'hCAFE, 1'b0, seq[14:0]}, TS[63:32], TS[31:0], NB_SAMPLES payload words, FCS {16'hC0DE, crc[15:0]}.
- States: HUNT, TS_MSB, TS_LSB, PAYLOAD, FCS.
- HUNT: pop every word; word with [31:16]==CAFE and [15]==0 captures seq -> TS_MSB; others discarded.
- TS_MSB: capture high half -> TS_LSB. TS_LSB: capture low half, update o_timestamp (all 64 bits at once), crc <= 16'hFFFF, count <= NB_SAMPLES-1 -> PAYLOAD.
- PAYLOAD: each popped word loaded into output register, crc updated; count==0 -> FCS, else decrement.
- CRC: poly 0x1021, init 0xFFFF, non-reflected, no final XOR, one 32-bit word per step, bit 31 first; identical to framer generator.
- FCS: [31:16]==C0DE -> o_crc_ok = (crc == [15:0]), crc mismatch increments o_crc_err_cnt; -> HUNT. [31:16]!=C0DE -> o_crc_ok=0, o_sync_loss_cnt++, -> HUNT. o_frame_done pulses in both cases.
- Sequence: first header after reset or sync loss sets reference, no error. Thereafter expected = prev+1 mod 2^15; mismatch sets o_seq_err for that frame, o_seq_err_cnt++, reference re-based to received value.
- Counters saturate at 16'hFFFF; i_clr_cnt has priority over a same-cycle increment.
- Payload forwarded before frame validated; downstream drops frame on o_crc_ok==0.

## Timing
- Reset: state HUNT, o_valid=0, o_sof=o_eof=0, o_data=0, o_timestamp=0, o_frame_done=0, o_crc_ok=0, o_seq_err=0, all counters 0, seq reference invalid.
- o_read = !i_empty & (state!=PAYLOAD | !o_valid | i_ready); never popped when empty.
- Payload latency: pop at cycle N -> o_valid at N+1; o_data/o_sof/o_eof held stable while o_valid & !i_ready.
- Full throughput: one word per cycle with i_ready high and FIFO non-empty; header/TS/FCS consume cycles without output.
- o_frame_done asserted the cycle after FCS pop; o_crc_ok/o_seq_err hold until next frame_done.
- Reset asserted mid-frame: immediate return to reset values; partial frame lost, no frame_done.

## Configuration
- RX_DEFRAMER_SEQ_CHECK_EN defined: sequence tracking as above.
- Undefined: no seq reference logic; o_seq_err constant 0, o_seq_err_cnt constant 0.

## Test plan
- Two back-to-back valid frames, seq 5 and 6, payload 0..255, i_ready=1 -> 512 payload words in order, o_sof on words 0, o_eof on 255, two frame_done with o_crc_ok=1, o_seq_err=0, counters 0.
- Flip bit 0 of payload word 17 -> o_crc_ok=0, o_crc_err_cnt=1, payload still forwarded unchanged otherwise.
- Seq 5 then 9 (macro defined) -> second frame_done with o_seq_err=1, o_seq_err_cnt=1; next frame seq 10 -> o_seq_err=0. Macro undefined -> no error.
- Three garbage words 0xDEADBEEF before header, then FCS word 0x12340000 -> garbage discarded with no output, o_sync_loss_cnt=1, next valid frame received cleanly.
- i_ready toggled 1/0 every cycle, i_empty random -> no word lost/duplicated, o_data stable while stalled, timestamp 0x0000_0001_0000_00FA on o_timestamp.
- Reset asserted at payload word 100 -> outputs at reset values next edge; subsequent frame with any seq -> o_seq_err=0.
